// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: stage contents and handshake in,
// stall/flush controls and status out.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_redirect;
    logic        mem_req;
    logic        dmem_ready;
    logic        dmem_valid;
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_stall;
    logic        ex_mem_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        mem_err;
    logic [31:0] stall_cycles;

    // The pipeline datapath owns the master side; the controller is the slave.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, mem_req, dmem_ready,
        input  dmem_valid, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_err, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, mem_req, dmem_ready,
        output dmem_valid, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_err, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use interlock, data-memory
// wait with watchdog abort, and branch/jump squash window.
module pipe_hazard_ctrl #(
    parameter int FETCH_LAT   = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        SQUASH   = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);
    localparam logic [1:0]  SQ_INIT = 2'(FETCH_LAT);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nxt;
    logic [1:0]  sq_cnt;
    logic [1:0]  sq_cnt_nxt;
    logic        mem_err_q;
    logic        mem_err_set;
    logic [31:0] stall_cnt;

    logic        stall_all;
    logic        dmem_valid;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        load_use;
    logic        mem_block;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    assign mem_block = hz.mem_req && !hz.dmem_ready;

    // Next-state and control decode. Reset forces every control low in the same
    // cycle. A stall taken in SQUASH keeps sq_cnt frozen, and the squash resumes
    // with the release cycle of the memory wait so no wrong-path fetch slips into IF/ID.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        sq_cnt_nxt   = sq_cnt;
        mem_err_set  = 1'b0;
        stall_all    = 1'b0;
        dmem_valid   = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    dmem_valid = hz.mem_req;
                    if (mem_block) begin
                        stall_all    = 1'b1;
                        state_nxt    = MEM_WAIT;
                        wait_cnt_nxt = 16'd1;
                    end else if (hz.ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_nxt   = SQUASH;
                        sq_cnt_nxt  = SQ_INIT;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                SQUASH: begin
                    dmem_valid = hz.mem_req;
                    if (mem_block) begin
                        stall_all    = 1'b1;
                        state_nxt    = MEM_WAIT;
                        wait_cnt_nxt = 16'd1;
                    end else begin
                        if_id_flush = 1'b1;
                        if (sq_cnt <= 2'd1) begin
                            sq_cnt_nxt = 2'd0;
                            state_nxt  = RUN;
                        end else begin
                            sq_cnt_nxt = sq_cnt - 2'd1;
                        end
                    end
                end
                MEM_WAIT: begin
                    dmem_valid = 1'b1;
                    if (hz.dmem_ready || (wait_cnt >= TIMEOUT)) begin
                        if (!hz.dmem_ready) begin
                            ex_mem_flush = 1'b1;
                            mem_err_set  = 1'b1;
                        end
                        wait_cnt_nxt = 16'd0;
                        if (sq_cnt != 2'd0) begin
                            if_id_flush = 1'b1;
                            sq_cnt_nxt  = sq_cnt - 2'd1;
                            state_nxt   = (sq_cnt == 2'd1) ? RUN : SQUASH;
                        end else begin
                            state_nxt = RUN;
                        end
                    end else begin
                        stall_all    = 1'b1;
                        wait_cnt_nxt = wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 16'd0;
                    sq_cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    // State, watchdog, squash counter, sticky error and saturating stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= 16'd0;
            sq_cnt    <= 2'd0;
            mem_err_q <= 1'b0;
            stall_cnt <= 32'd0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            sq_cnt    <= sq_cnt_nxt;
            mem_err_q <= mem_err_q | mem_err_set;
            if (hz.pc_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign hz.dmem_valid   = dmem_valid;
    assign hz.pc_stall     = stall_all | pc_stall;
    assign hz.if_id_stall  = (stall_all | if_id_stall) & ~if_id_flush;
    assign hz.id_ex_stall  = stall_all & ~id_ex_flush;
    assign hz.ex_mem_stall = stall_all & ~ex_mem_flush;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.mem_err      = mem_err_q;
    assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances (long and short watchdog)
// share stage stimulus; only the short-watchdog copy sees the timeout traffic.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_redirect;
    logic        mem_req;
    logic        mem_req_b;
    logic        dmem_ready;
    int          checks;
    int          errors;

    logic [7:0]  ctl_a;
    logic [7:0]  ctl_b;

    pipe_hazard_ctrl_if ifa ();
    pipe_hazard_ctrl_if ifb ();

    pipe_hazard_ctrl #(.FETCH_LAT(2), .MEM_TIMEOUT(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .hz    (ifa.slave)
    );

    pipe_hazard_ctrl #(.FETCH_LAT(2), .MEM_TIMEOUT(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .hz    (ifb.slave)
    );

    assign ifa.id_rs1      = id_rs1;
    assign ifa.id_rs2      = id_rs2;
    assign ifa.id_use_rs1  = id_use_rs1;
    assign ifa.id_use_rs2  = id_use_rs2;
    assign ifa.ex_rd       = ex_rd;
    assign ifa.ex_mem_read = ex_mem_read;
    assign ifa.ex_redirect = ex_redirect;
    assign ifa.mem_req     = mem_req;
    assign ifa.dmem_ready  = dmem_ready;
    assign ifb.id_rs1      = id_rs1;
    assign ifb.id_rs2      = id_rs2;
    assign ifb.id_use_rs1  = id_use_rs1;
    assign ifb.id_use_rs2  = id_use_rs2;
    assign ifb.ex_rd       = ex_rd;
    assign ifb.ex_mem_read = ex_mem_read;
    assign ifb.ex_redirect = ex_redirect;
    assign ifb.mem_req     = mem_req_b;
    assign ifb.dmem_ready  = dmem_ready;

    // Control word: {dmem_valid, pc/if_id/id_ex/ex_mem stall, if_id/id_ex/ex_mem flush}.
    assign ctl_a = {ifa.dmem_valid, ifa.pc_stall, ifa.if_id_stall, ifa.id_ex_stall,
                    ifa.ex_mem_stall, ifa.if_id_flush, ifa.id_ex_flush, ifa.ex_mem_flush};
    assign ctl_b = {ifb.dmem_valid, ifb.pc_stall, ifb.if_id_stall, ifb.id_ex_stall,
                    ifb.ex_mem_stall, ifb.if_id_flush, ifb.id_ex_flush, ifb.ex_mem_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic mr, input logic redir, input logic mreq,
                                 input logic mreq_b, input logic rdy);
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        ex_rd       = rd;
        ex_mem_read = mr;
        ex_redirect = redir;
        mem_req     = mreq;
        mem_req_b   = mreq_b;
        dmem_ready  = rdy;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        advance();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_ctl_a", 32'(ctl_a), 32'h00);
        checkOutput("reset_ctl_b", 32'(ctl_b), 32'h00);
        checkOutput("reset_mem_err", 32'(ifa.mem_err), 32'd0);
        checkOutput("reset_stall_cycles", ifa.stall_cycles, 32'd0);
        advance();
        reset = 1'b0;

        // Load-use on rs1, then the ex_rd==0 and rs2 variants
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs1_ctl", 32'(ctl_a), 32'h62);
        advance();
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_after_ctl", 32'(ctl_a), 32'h00);
        checkOutput("lu_stall_cycles", ifa.stall_cycles, 32'd1);
        advance();
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rd0_ctl", 32'(ctl_a), 32'h00);
        advance();
        applyStimulus(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs2_ctl", 32'(ctl_a), 32'h62);
        advance();
        applyStimulus(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs2_unused_ctl", 32'(ctl_a), 32'h00);
        checkOutput("lu_rs2_stall_cycles", ifa.stall_cycles, 32'd2);
        advance();

        // Redirect pulse: three IF/ID bubbles, ID/EX flushed only in the first
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("redir_c0_ctl", 32'(ctl_a), 32'h06);
        advance();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("redir_c1_ctl", 32'(ctl_a), 32'h04);
        advance();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("redir_c2_ctl", 32'(ctl_a), 32'h04);
        advance();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("redir_c3_ctl", 32'(ctl_a), 32'h00);
        checkOutput("redir_stall_cycles", ifa.stall_cycles, 32'd2);
        advance();

        // Four-cycle memory wait then ready
        for (int i = 0; i < 4; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("mw_wait_ctl", 32'(ctl_a), 32'hF8);
            advance();
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mw_ready_ctl", 32'(ctl_a), 32'h80);
        advance();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mw_after_ctl", 32'(ctl_a), 32'h00);
        checkOutput("mw_stall_cycles", ifa.stall_cycles, 32'd6);
        checkOutput("mw_mem_err", 32'(ifa.mem_err), 32'd0);
        advance();

        // Watchdog abort on the short-timeout instance
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("to_wait_ctl", 32'(ctl_b), 32'hF8);
            advance();
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("to_abort_ctl", 32'(ctl_b), 32'h81);
        checkOutput("to_abort_mem_err", 32'(ifb.mem_err), 32'd0);
        advance();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("to_after_ctl", 32'(ctl_b), 32'h00);
        checkOutput("to_after_mem_err", 32'(ifb.mem_err), 32'd1);
        advance();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("to_sticky_mem_err", 32'(ifb.mem_err), 32'd1);
        checkOutput("to_stall_cycles_b", ifb.stall_cycles, 32'd5);
        advance();

        // Load-use coinciding with redirect: redirect wins, no stall
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_redir_ctl", 32'(ctl_a), 32'h06);
        advance();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("lu_redir_squash_ctl", 32'(ctl_a), 32'h04);
            advance();
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_redir_done_ctl", 32'(ctl_a), 32'h00);
        advance();

        // Redirect raised during a memory wait is honoured after the release
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("mwr_c0_ctl", 32'(ctl_a), 32'hF8);
        advance();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("mwr_c1_ctl", 32'(ctl_a), 32'hF8);
        advance();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("mwr_release_ctl", 32'(ctl_a), 32'h80);
        advance();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("mwr_redir_ctl", 32'(ctl_a), 32'h06);
        checkOutput("mwr_stall_cycles", ifa.stall_cycles, 32'd8);
        advance();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("mwr_squash_ctl", 32'(ctl_a), 32'h04);
            advance();
        end

        // Reset in the second MEM_WAIT cycle
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_c0_ctl", 32'(ctl_a), 32'hF8);
        advance();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_c1_ctl", 32'(ctl_a), 32'hF8);
        advance();
        reset = 1'b1;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_during_ctl", 32'(ctl_a), 32'h00);
        advance();
        reset = 1'b0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_after_ctl", 32'(ctl_a), 32'h00);
        checkOutput("rst_after_stall_cycles", ifa.stall_cycles, 32'd0);
        checkOutput("rst_after_mem_err_a", 32'(ifa.mem_err), 32'd0);
        checkOutput("rst_after_mem_err_b", 32'(ifb.mem_err), 32'd0);
        advance();
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_run_lu_ctl", 32'(ctl_a), 32'h62);
        advance();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
